// File: rtl/fifo_rd_if.sv
// Read-side port of the team fifo: empty/data from the FIFO, rd_en from the reader.
// A pop in cycle t presents the popped entry on data in cycle t+1.
interface fifo_rd_if #(
   parameter int DATA_W = 32
);
   logic              empty;
   logic              rd_en;
   logic [DATA_W-1:0] data;

   modport master (input empty, input data, output rd_en);
   modport slave  (output empty, output data, input rd_en);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a fifo_rd_if port into a valid/ready stream through a 2-entry output buffer.
// Optional transfer counter enabled by macro FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
   parameter int DATA_W     = 32,
   parameter int OBUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   fifo_rd_if.master         rd_if,
   input  logic              en_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic              busy_o,
   output logic [31:0]       xfer_cnt_o
);

   // Stream handshake: once m_valid_o is high, m_valid_o and m_data_o hold
   // steady until a cycle with m_ready_i also high; that cycle is one transfer.

   generate
      if (OBUF_DEPTH != 2) begin : g_bad_depth
         $error("fifo_stream_reader: OBUF_DEPTH must be 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              inflight;
   logic              capture;
   logic              out_fire;
   logic              rd_en;
   logic [1:0]        occ;
   logic [2:0]        level;
   logic [DATA_W-1:0] slot0;
   logic [DATA_W-1:0] slot1;

   assign capture     = inflight;
   assign rd_if.rd_en = rd_en;
   assign m_data_o    = slot0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_EMPTY;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= rd_en;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: begin
            if (capture) state_nxt = ST_ONE;
         end
         ST_ONE: begin
            if (capture && !out_fire)      state_nxt = ST_TWO;
            else if (!capture && out_fire) state_nxt = ST_EMPTY;
         end
         ST_TWO: begin
            if (out_fire) state_nxt = ST_ONE;
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // Pop only when the word it returns is guaranteed a free slot on arrival.
   always_comb begin
      m_valid_o = (state != ST_EMPTY);
      out_fire  = m_valid_o && m_ready_i;
      case (state)
         ST_ONE:  occ = 2'd1;
         ST_TWO:  occ = 2'd2;
         default: occ = 2'd0;
      endcase
      level  = {1'b0, occ} + {2'b00, inflight};
      rd_en  = !rst && en_i && !rd_if.empty &&
               ((level - {2'b00, out_fire}) < 3'd2);
      busy_o = inflight || m_valid_o;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (capture) slot0 <= rd_if.data;
            end
            ST_ONE: begin
               if (capture && out_fire)       slot0 <= rd_if.data;
               else if (capture && !out_fire) slot1 <= rd_if.data;
            end
            ST_TWO: begin
               if (out_fire) slot0 <= slot1;
            end
            default: ;
         endcase
      end
   end

`ifdef FIFO_STREAM_READER_CNT_EN
   logic [31:0] xfer_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           xfer_cnt <= 32'd0;
      else if (out_fire) xfer_cnt <= xfer_cnt + 32'd1;
   end

   assign xfer_cnt_o = xfer_cnt;
`else
   assign xfer_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural fifo model, directed phases, and a
// negedge monitor that pops an expected queue on every stream transfer.
module tb_fifo_stream_reader;

   logic        clk;
   logic        rst;
   logic        en_i;
   logic        m_ready_i;
   logic [31:0] m_data_o;
   logic        m_valid_o;
   logic        busy_o;
   logic [31:0] xfer_cnt_o;

   logic        wr_en;
   logic [31:0] wr_data;
   logic [31:0] fq[$];
   int          pops;

   logic [31:0] exp_q[$];
   int          n_assert;
   int          n_fail;
   int          tb_xfers;
   logic        hold_v;
   logic [31:0] hold_d;

   fifo_rd_if #(.DATA_W(32)) fif ();

   fifo_stream_reader #(.DATA_W(32), .OBUF_DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_if      (fif),
      .en_i       (en_i),
      .m_data_o   (m_data_o),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .busy_o     (busy_o),
      .xfer_cnt_o (xfer_cnt_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // fifo model: registered empty, one-cycle read latency
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fq.delete();
         fif.empty <= 1'b1;
         fif.data  <= 32'd0;
      end else begin
         if (fif.rd_en && !fif.empty) begin
            fif.data <= fq.pop_front();
            pops++;
         end
         if (wr_en) fq.push_back(wr_data);
         fif.empty <= (fq.size() == 0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // driver tasks (called at posedge+1)
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr_word(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      tick(1);
      wr_en   = 1'b0;
   endtask

   task automatic neg_then_pos();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         tb_xfers = 0;
         hold_v   = 1'b0;
      end else begin
         if (fif.rd_en) chk("rd_en_while_empty", {31'd0, fif.empty}, 32'd0);
         if (hold_v) begin
            chk("valid_held", {31'd0, m_valid_o}, 32'd1);
            chk("data_held", m_data_o, hold_d);
         end
         if (m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_word", m_data_o, 32'hDEAD_BEEF);
            else chk("stream_data", m_data_o, exp_q.pop_front());
            tb_xfers++;
         end
         hold_v = m_valid_o && !m_ready_i;
         hold_d = m_data_o;
      end
   end

   function automatic logic [31:0] exp_cnt(input int n);
`ifdef FIFO_STREAM_READER_CNT_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   initial begin
      int p0;
      int vcount;
      int sent;
      int guard;
      n_assert = 0; n_fail = 0; tb_xfers = 0; pops = 0;
      hold_v = 1'b0; hold_d = 32'd0;
      rst = 1'b1; en_i = 1'b1; m_ready_i = 1'b1; wr_en = 1'b0; wr_data = 32'd0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
      chk("rst_rd_en", {31'd0, fif.rd_en}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_data", m_data_o, 32'd0);
      chk("rst_cnt", xfer_cnt_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick(2);

      // A: 4 words, latency and back-to-back delivery
      fork
         begin
            wr_word(32'hA0); wr_word(32'hA1); wr_word(32'hA2); wr_word(32'hA3);
         end
         begin
            @(negedge clk); chk("a_empty_k", {31'd0, fif.empty}, 32'd1);
            neg_then_pos();
            @(negedge clk); chk("a_rd_en_t", {31'd0, fif.rd_en}, 32'd1);
            chk("a_valid_t", {31'd0, m_valid_o}, 32'd0);
            neg_then_pos();
            @(negedge clk); chk("a_valid_t1", {31'd0, m_valid_o}, 32'd0);
            neg_then_pos();
            @(negedge clk); chk("a_valid_t2", {31'd0, m_valid_o}, 32'd1);
            chk("a_data_t2", m_data_o, 32'hA0);
            for (int i = 0; i < 3; i++) begin
               neg_then_pos();
               @(negedge clk); chk("a_valid_run", {31'd0, m_valid_o}, 32'd1);
            end
            neg_then_pos();
            @(negedge clk); chk("a_valid_end", {31'd0, m_valid_o}, 32'd0);
            neg_then_pos();
         end
      join
      tick(2);
      chk("a_drained", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
      chk("a_cnt", xfer_cnt_o, 32'd4);
`endif

      // B: preload 8, stall 10 cycles, release
      en_i = 1'b0; m_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) wr_word(32'hB0 + 32'(i));
      tick(1);
      p0 = pops;
      en_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            chk("b_stall_valid", {31'd0, m_valid_o}, 32'd1);
            chk("b_stall_data", m_data_o, 32'hB0);
         end
         neg_then_pos();
      end
      chk("b_pops", 32'(pops - p0), 32'd2);
      m_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); chk("b_no_bubble", {31'd0, m_valid_o}, 32'd1);
         neg_then_pos();
      end
      @(negedge clk); chk("b_valid_end", {31'd0, m_valid_o}, 32'd0);
      neg_then_pos();
      chk("b_drained", 32'(exp_q.size()), 32'd0);
      chk("b_cnt", xfer_cnt_o, exp_cnt(tb_xfers));

      // C: 200 words with random ready
      sent = 0; guard = 0;
      while ((sent < 200 || exp_q.size() != 0) && guard < 3000) begin
         if (sent < 200) begin
            wr_en = 1'b1;
            wr_data = 32'h1000 + 32'(sent);
            exp_q.push_back(wr_data);
            sent++;
         end else begin
            wr_en = 1'b0;
         end
         m_ready_i = 1'($urandom_range(0, 1));
         tick(1);
         guard++;
      end
      wr_en = 1'b0; m_ready_i = 1'b1;
      chk("c_in_budget", {31'd0, guard < 3000}, 32'd1);
      chk("c_drained", 32'(exp_q.size()), 32'd0);
      tick(2);
      chk("c_cnt", xfer_cnt_o, exp_cnt(tb_xfers));

      // D: en_i drops right after a single pop
      en_i = 1'b0;
      wr_word(32'hD0); wr_word(32'hD1); wr_word(32'hD2);
      tick(2);
      p0 = pops;
      en_i = 1'b1;
      tick(1);
      en_i = 1'b0;
      @(negedge clk);
      chk("d_busy_inflight", {31'd0, busy_o}, 32'd1);
      chk("d_valid_inflight", {31'd0, m_valid_o}, 32'd0);
      neg_then_pos();
      @(negedge clk);
      chk("d_valid", {31'd0, m_valid_o}, 32'd1);
      chk("d_data", m_data_o, 32'hD0);
      chk("d_busy", {31'd0, busy_o}, 32'd1);
      neg_then_pos();
      @(negedge clk);
      chk("d_busy_fall", {31'd0, busy_o}, 32'd0);
      chk("d_valid_fall", {31'd0, m_valid_o}, 32'd0);
      neg_then_pos();
      tick(5);
      chk("d_pops", 32'(pops - p0), 32'd1);
      en_i = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         tick(1);
         guard++;
      end
      chk("d_drained", 32'(exp_q.size()), 32'd0);
      tick(2);

      // E: async reset while buffer holds two words
      en_i = 1'b0; m_ready_i = 1'b0;
      wr_word(32'hE0); wr_word(32'hE1); wr_word(32'hE2); wr_word(32'hE3);
      en_i = 1'b1;
      tick(6);
      @(negedge clk);
      chk("e_pre_valid", {31'd0, m_valid_o}, 32'd1);
      chk("e_pre_data", m_data_o, 32'hE0);
      #2;
      rst = 1'b1;
      #1;
      chk("e_rst_valid", {31'd0, m_valid_o}, 32'd0);
      chk("e_rst_rd_en", {31'd0, fif.rd_en}, 32'd0);
      chk("e_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("e_rst_cnt", xfer_cnt_o, 32'd0);
      chk("e_rst_data", m_data_o, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_ready_i = 1'b1;
      tick(2);

      // F: single word into an empty fifo
      p0 = pops; vcount = 0;
      wr_word(32'hF0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_valid_o) vcount++;
         neg_then_pos();
      end
      chk("f_valid_cycles", 32'(vcount), 32'd1);
      chk("f_pops", 32'(pops - p0), 32'd1);
      chk("f_busy", {31'd0, busy_o}, 32'd0);
      chk("f_drained", 32'(exp_q.size()), 32'd0);
      chk("f_cnt", xfer_cnt_o, exp_cnt(tb_xfers));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
